// File: rtl/coin_return_dispenser_pkg.sv
// Shared definitions for the coin return datapath: coin count, amount width,
// return FSM encodings and the amount type.
package coin_return_dispenser_pkg;

  localparam int kNumCoins  = 3;
  localparam int kTotalBits = 31;

  localparam logic [1:0] kRetIdle     = 2'd0;
  localparam logic [1:0] kRetDispense = 2'd1;
  localparam logic [1:0] kRetDone     = 2'd2;

  typedef logic [kTotalBits-1:0] amount_t;

endpackage

// File: rtl/coin_return_dispenser_select.sv
// Greedy coin picker: chooses the largest in-stock coin that still fits into
// the remaining amount. Higher index wins because the loop visits it last.
module coin_select_greedy
  import coin_return_dispenser_pkg::*;
(
  input  amount_t                      remaining,
  input  logic    [kNumCoins-1:0]      stock_nz,
  input  amount_t [kNumCoins-1:0]      coin_value,
  output logic                         found,
  output logic    [kNumCoins-1:0]      sel_onehot
);

  always_comb begin
    found      = 1'b0;
    sel_onehot = '0;
    for (int k = 0; k < kNumCoins; k++) begin
      if (stock_nz[k] && (coin_value[k] <= remaining)) begin
        found         = 1'b1;
        sel_onehot    = '0;
        sel_onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_return_dispenser.sv
// Change-return engine: pays a latched amount out one coin per cycle, largest
// coin first, tracking per-coin stock and reporting any unpayable remainder.
module coin_return_dispenser
  import coin_return_dispenser_pkg::*;
#(
  parameter int COIN0_VALUE = 100,
  parameter int COIN1_VALUE = 500,
  parameter int COIN2_VALUE = 1000,
  parameter int INIT_STOCK  = 8,
  parameter int STOCK_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [kNumCoins-1:0] i_input_coin,
  input  logic                 i_trigger_return,
  input  amount_t              i_return_amount,
  output logic [kNumCoins-1:0] o_return_coin,
  output logic                 o_busy,
  output logic                 o_done,
  output amount_t              o_shortfall
);

  localparam logic [STOCK_BITS-1:0] kStockInit = STOCK_BITS'(INIT_STOCK);
  localparam logic [STOCK_BITS-1:0] kStockMax  = '1;

  logic [1:0]            state_q, state_d;
  amount_t               remaining_q, remaining_d;
  amount_t               shortfall_q, shortfall_d;
  logic [kNumCoins-1:0]  ret_coin_q, ret_coin_d;
  logic [STOCK_BITS-1:0] stock_q [kNumCoins];
  logic [STOCK_BITS-1:0] stock_d [kNumCoins];

  amount_t [kNumCoins-1:0] coin_value;
  logic    [kNumCoins-1:0] stock_nz;
  logic    [kNumCoins-1:0] sel_onehot;
  logic                    sel_found;
  logic                    dispensing;
  amount_t                 sel_value;

  assign coin_value = {amount_t'(COIN2_VALUE), amount_t'(COIN1_VALUE),
                       amount_t'(COIN0_VALUE)};

  always_comb begin
    for (int k = 0; k < kNumCoins; k++) begin
      stock_nz[k] = (stock_q[k] != '0);
    end
  end

  coin_select_greedy u_select (
    .remaining  (remaining_q),
    .stock_nz   (stock_nz),
    .coin_value (coin_value),
    .found      (sel_found),
    .sel_onehot (sel_onehot)
  );

  assign dispensing = (state_q == kRetDispense) && sel_found;

  always_comb begin
    sel_value = '0;
    for (int k = 0; k < kNumCoins; k++) begin
      if (sel_onehot[k]) sel_value = sel_value | coin_value[k];
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    shortfall_d = shortfall_q;
    ret_coin_d  = '0;
    case (state_q)
      kRetIdle: begin
        if (i_trigger_return) begin
          remaining_d = i_return_amount;
          shortfall_d = '0;
          state_d     = (i_return_amount == '0) ? kRetDone : kRetDispense;
        end
      end
      kRetDispense: begin
        if (sel_found) begin
          ret_coin_d  = sel_onehot;
          remaining_d = remaining_q - sel_value;
        end else begin
          shortfall_d = remaining_q;
          state_d     = kRetDone;
        end
      end
      default: state_d = kRetIdle;
    endcase
  end

  // A deposit and an ejection of the same coin in one cycle cancel out.
  always_comb begin
    for (int k = 0; k < kNumCoins; k++) begin
      stock_d[k] = stock_q[k];
      if (i_input_coin[k] && !(dispensing && sel_onehot[k])) begin
        if (stock_q[k] != kStockMax) stock_d[k] = stock_q[k] + 1'b1;
      end else if (!i_input_coin[k] && dispensing && sel_onehot[k]) begin
        stock_d[k] = stock_q[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= kRetIdle;
      remaining_q <= '0;
      shortfall_q <= '0;
      ret_coin_q  <= '0;
      for (int k = 0; k < kNumCoins; k++) stock_q[k] <= kStockInit;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      shortfall_q <= shortfall_d;
      ret_coin_q  <= ret_coin_d;
      for (int k = 0; k < kNumCoins; k++) stock_q[k] <= stock_d[k];
    end
  end

  assign o_return_coin = ret_coin_q;
  assign o_busy        = (state_q == kRetDispense);
  assign o_done        = (state_q == kRetDone);
  assign o_shortfall   = shortfall_q;

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Directed bench for coin_return_dispenser: three instances with stock preloads
// of 8, 1 and 0 driven from a vector table plus reset/retrigger sequences.
module tb_coin_return_dispenser;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  in_coin  [3];
  logic        trig     [3];
  logic [30:0] amt      [3];
  logic [2:0]  ret_coin [3];
  logic        busy     [3];
  logic        done     [3];
  logic [30:0] shortf   [3];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  coin_return_dispenser #(.INIT_STOCK(8)) u0 (
    .clk(clk), .reset(reset), .i_input_coin(in_coin[0]),
    .i_trigger_return(trig[0]), .i_return_amount(amt[0]),
    .o_return_coin(ret_coin[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_shortfall(shortf[0]));

  coin_return_dispenser #(.INIT_STOCK(1)) u1 (
    .clk(clk), .reset(reset), .i_input_coin(in_coin[1]),
    .i_trigger_return(trig[1]), .i_return_amount(amt[1]),
    .o_return_coin(ret_coin[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_shortfall(shortf[1]));

  coin_return_dispenser #(.INIT_STOCK(0)) u2 (
    .clk(clk), .reset(reset), .i_input_coin(in_coin[2]),
    .i_trigger_return(trig[2]), .i_return_amount(amt[2]),
    .o_return_coin(ret_coin[2]), .o_busy(busy[2]), .o_done(done[2]),
    .o_shortfall(shortf[2]));

  typedef struct {
    int          inst;
    logic [2:0]  dep;
    int          dep_cycles;
    logic [30:0] amount;
    int          n2;
    int          n1;
    int          n0;
    logic [30:0] short_amt;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_coin_u%0d", tag, i), 32'(ret_coin[i]), 0);
      check($sformatf("%s_busy_u%0d", tag, i), 32'(busy[i]), 0);
      check($sformatf("%s_done_u%0d", tag, i), 32'(done[i]), 0);
      check($sformatf("%s_short_u%0d", tag, i), 32'(shortf[i]), 0);
    end
  endtask

  // Coins come out as n2 x 100b, then n1 x 010b, then n0 x 001b; cycle 0 is
  // the sample right after the trigger edge.
  task automatic run_return(input string tag, input int inst,
                            input logic [2:0] dep, input int dep_cycles,
                            input logic [30:0] amount, input int n2,
                            input int n1, input int n0,
                            input logic [30:0] short_amt, input int retrig);
    int total;
    int exp_done_cyc;
    int cyc;
    bit ended;
    logic [2:0] exp_coin;
    total        = n2 + n1 + n0;
    exp_done_cyc = (amount == 0) ? 0 : total + 1;
    for (int i = 0; i < dep_cycles; i++) begin
      @(negedge clk);
      in_coin[inst] = dep;
    end
    @(negedge clk);
    in_coin[inst] = 3'b000;
    trig[inst]    = 1'b1;
    amt[inst]     = amount;
    @(negedge clk);
    trig[inst] = 1'b0;
    cyc   = 0;
    ended = 1'b0;
    while (!ended && cyc < 400) begin
      if (cyc >= 1 && cyc <= n2)                exp_coin = 3'b100;
      else if (cyc > n2 && cyc <= n2 + n1)      exp_coin = 3'b010;
      else if (cyc > n2 + n1 && cyc <= total)   exp_coin = 3'b001;
      else                                      exp_coin = 3'b000;
      check($sformatf("%s_coin_c%0d", tag, cyc), 32'(ret_coin[inst]), 32'(exp_coin));
      check($sformatf("%s_busy_c%0d", tag, cyc), 32'(busy[inst]),
            32'(cyc < exp_done_cyc));
      if (done[inst]) begin
        ended = 1'b1;
      end else begin
        trig[inst] = (cyc == retrig);
        amt[inst]  = 31'd500;
        @(negedge clk);
        trig[inst] = 1'b0;
        cyc++;
      end
    end
    check($sformatf("%s_done_seen", tag), 32'(ended), 1);
    check($sformatf("%s_done_cycle", tag), 32'(cyc), 32'(exp_done_cyc));
    check($sformatf("%s_shortfall", tag), 32'(shortf[inst]), 32'(short_amt));
    @(negedge clk);
    check($sformatf("%s_done_pulse", tag), 32'(done[inst]), 0);
    check($sformatf("%s_short_hold", tag), 32'(shortf[inst]), 32'(short_amt));
    @(negedge clk);
    check($sformatf("%s_idle_busy", tag), 32'(busy[inst]), 0);
    check($sformatf("%s_idle_coin", tag), 32'(ret_coin[inst]), 0);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_coin[i] = 3'b000;
      trig[i]    = 1'b0;
      amt[i]     = '0;
    end

    //            inst dep  depc amount        n2   n1 n0 shortfall
    tbl[0]  = '{0, 3'b000, 0,   31'd1600,     1,   1, 1, 31'd0};
    tbl[1]  = '{0, 3'b000, 0,   31'd150,      0,   0, 1, 31'd50};
    tbl[2]  = '{0, 3'b000, 0,   31'd0,        0,   0, 0, 31'd0};
    tbl[3]  = '{0, 3'b000, 0,   31'd4000,     4,   0, 0, 31'd0};
    tbl[4]  = '{0, 3'b000, 0,   31'd5000,     3,   4, 0, 31'd0};
    tbl[5]  = '{0, 3'b000, 0,   31'd2000,     0,   3, 5, 31'd0};
    tbl[6]  = '{0, 3'b000, 0,   31'd350,      0,   0, 1, 31'd250};
    tbl[7]  = '{0, 3'b000, 0,   31'd100,      0,   0, 0, 31'd100};
    tbl[8]  = '{1, 3'b000, 0,   31'd2000,     1,   1, 1, 31'd400};
    tbl[9]  = '{2, 3'b100, 1,   31'd1000,     1,   0, 0, 31'd0};
    tbl[10] = '{2, 3'b000, 0,   31'd1000,     0,   0, 0, 31'd1000};
    tbl[11] = '{2, 3'b100, 300, 31'd256000,   255, 0, 0, 31'd1000};
    tbl[12] = '{2, 3'b011, 2,   31'd700,      0,   1, 2, 31'd0};

    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    for (int v = 0; v < 13; v++) begin
      run_return($sformatf("v%0d", v), tbl[v].inst, tbl[v].dep,
                 tbl[v].dep_cycles, tbl[v].amount, tbl[v].n2, tbl[v].n1,
                 tbl[v].n0, tbl[v].short_amt, -1);
    end

    // Fresh stock, then a second trigger pulsed mid-dispense must be dropped.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_return("retrig", 0, 3'b000, 0, 31'd3000, 3, 0, 0, 31'd0, 2);

    // Reset after the first coin aborts the session at once.
    @(negedge clk);
    trig[0] = 1'b1;
    amt[0]  = 31'd3000;
    @(negedge clk);
    trig[0] = 1'b0;
    @(negedge clk);
    check("abort_first_coin", 32'(ret_coin[0]), 32'(3'b100));
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("abort");
    @(negedge clk);
    reset = 1'b0;

    // Every stock back at 8: 9000 = 8 x 1000 + 2 x 500.
    run_return("restock", 0, 3'b000, 0, 31'd9000, 8, 2, 0, 31'd0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
